// File: rtl/boe_frame_feeder.sv
// ---------------------------------------------------------------------------
// boe_frame_feeder
//
// Upstream feeder for the BOE (sum / max / sort) stage. It accepts a
// valid/ready byte stream carrying a per-frame length header, buffers one
// complete frame of MIN_N..MAX_N bytes, then plays it into BOE on
// back-to-back cycles. BOE is held in reset whenever no frame is in flight,
// so every frame starts from BOE's first state.
//
// Frame cadence at BOE (N = frame length):
//   SEND : N cycles, data_in = buf[0..N-1], data_num = N, boe_rst = 0
//   WAIT : N+2 cycles while BOE emits sum, max and N sorted bytes;
//          frame_done pulses on the last of these cycles
//   then one IDLE cycle with boe_rst = 1 before the next frame can start.
//
// Optional build macro:
//   BOE_FEED_LEN_CHECK_EN  defined   : a header with in_num outside
//                                      MIN_N..MAX_N is dropped with an err
//                                      pulse and no frame is launched.
//                          undefined : in_num is clamped into MIN_N..MAX_N
//                                      and the frame proceeds.
//
// Ports:
//   clk        in   rising-edge clock, shared with BOE
//   rst        in   asynchronous, active-high reset
//   in_valid   in   source beat valid
//   in_ready   out  beat accepted when in_valid && in_ready
//   in_sof     in   beat is the first of a frame (carries in_num)
//   in_num     in   frame length N, sampled on sof beats only
//   in_data    in   data byte
//   boe_rst    out  drives BOE rst (synchronous inside BOE)
//   data_num   out  drives BOE data_num
//   data_in    out  drives BOE data_in
//   frame_done out  one-cycle pulse on the last cycle of the BOE result stream
//   err        out  one-cycle pulse on a protocol error
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module boe_frame_feeder #(
    parameter int MAX_N  = 6,
    parameter int MIN_N  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [2:0]        in_num,
    input  logic [DATA_W-1:0] in_data,
    output logic              boe_rst,
    output logic [2:0]        data_num,
    output logic [DATA_W-1:0] data_in,
    output logic              frame_done,
    output logic              err
);

    localparam logic [2:0] MIN_L = 3'(MIN_N);
    localparam logic [2:0] MAX_L = 3'(MAX_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] frame_buf [MAX_N];
    logic [2:0]        n_len;     // length of the frame being filled / played
    logic [2:0]        cnt;       // bytes written into frame_buf so far
    logic [2:0]        k;         // index of the next byte to present in SEND
    logic [2:0]        wcnt;      // WAIT cycle index, 0..N+1

    logic              accept;
    logic              hdr_ok;    // header length usable for a new frame
    logic [2:0]        hdr_len;   // length to load from a header beat

`ifdef BOE_FEED_LEN_CHECK_EN
    function automatic logic len_ok(input logic [2:0] v);
        return (v >= MIN_L) && (v <= MAX_L);
    endfunction

    assign hdr_ok  = len_ok(in_num);
    assign hdr_len = in_num;
`else
    // Saturate an out-of-range header length into the legal window.
    function automatic logic [2:0] sat_len(input logic [2:0] v);
        if (v < MIN_L)
            return MIN_L;
        else if (v > MAX_L)
            return MAX_L;
        else
            return v;
    endfunction

    assign hdr_ok  = 1'b1;
    assign hdr_len = sat_len(in_num);
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            boe_rst    <= 1'b1;
            data_num   <= '0;
            data_in    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            n_len      <= '0;
            cnt        <= '0;
            k          <= '0;
            wcnt       <= '0;
            for (int i = 0; i < MAX_N; i++)
                frame_buf[i] <= '0;
        end else begin
            // Pulses default low; only the cycle that raises them holds them.
            frame_done <= 1'b0;
            err        <= 1'b0;

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    boe_rst  <= 1'b1;
                    if (accept) begin
                        if (in_sof && hdr_ok) begin
                            frame_buf[0] <= in_data;
                            n_len        <= hdr_len;
                            cnt          <= 3'd1;
                            state        <= FILL;
                        end else begin
                            // Missing sof, or rejected header length.
                            err <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    in_ready <= 1'b1;
                    boe_rst  <= 1'b1;
                    if (accept) begin
                        if (in_sof) begin
                            // A new header mid-frame abandons the partial frame.
                            err <= 1'b1;
                            if (hdr_ok) begin
                                frame_buf[0] <= in_data;
                                n_len        <= hdr_len;
                                cnt          <= 3'd1;
                            end else begin
                                cnt   <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            frame_buf[cnt] <= in_data;
                            cnt            <= cnt + 3'd1;
                            if (cnt + 3'd1 == n_len) begin
                                // Last byte: release BOE and present byte 0
                                // on the very next cycle. frame_buf[0] was
                                // written on an earlier beat, so it is stable.
                                state    <= SEND;
                                in_ready <= 1'b0;
                                boe_rst  <= 1'b0;
                                data_num <= n_len;
                                data_in  <= frame_buf[0];
                                k        <= 3'd1;
                            end
                        end
                    end
                end

                SEND: begin
                    if (k == n_len) begin
                        state   <= WAIT;
                        data_in <= '0;
                        wcnt    <= '0;
                    end else begin
                        data_in <= frame_buf[k];
                        k       <= k + 3'd1;
                    end
                end

                WAIT: begin
                    if (wcnt == n_len + 3'd1) begin
                        state    <= IDLE;
                        boe_rst  <= 1'b1;
                        in_ready <= 1'b1;
                        data_num <= '0;
                        cnt      <= '0;
                        k        <= '0;
                        wcnt     <= '0;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                        // Registered pulse: raise it on the edge entering
                        // the final WAIT cycle (index N+1).
                        if (wcnt == n_len)
                            frame_done <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boe_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_boe_frame_feeder
//
// Directed bench for boe_frame_feeder. Frames are driven through the
// valid/ready port; the SEND/WAIT cadence, BOE reset control, frame_done and
// err pulses are compared with hand-computed values. The byte stream seen by
// BOE is accumulated to confirm the sum and max BOE would report.
// ---------------------------------------------------------------------------
module tb_boe_frame_feeder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [2:0] in_num;
    logic [7:0] in_data;
    logic       boe_rst;
    logic [2:0] data_num;
    logic [7:0] data_in;
    logic       frame_done;
    logic       err;

    int n_cmp;
    int n_bad;

    logic [7:0] fr [6];

    boe_frame_feeder #(
        .MAX_N  (6),
        .MIN_N  (2),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_num     (in_num),
        .in_data    (in_data),
        .boe_rst    (boe_rst),
        .data_num   (data_num),
        .data_in    (data_in),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic beat(input logic sof, input logic [2:0] num, input logic [7:0] d);
        int  t;
        bit  acc;
        t   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_num   = num;
        in_data  = d;
        while (!acc && t < 40) begin
            acc = (in_ready === 1'b1);
            step();
            t++;
        end
        if (!acc)
            chk("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [2:0] num_hdr, input int n);
        beat(1'b1, num_hdr, fr[0]);
        for (int i = 1; i < n; i++)
            beat(1'b0, 3'd0, fr[i]);
    endtask

    // Called one unit after the edge that accepted the last byte.
    // A stray beat is held on the port throughout: it must be neither
    // accepted nor flagged while the frame is in flight.
    task automatic check_play(input string tag, input int n, input int exp_sum, input int exp_max);
        int sum;
        int mx;
        sum = 0;
        mx  = 0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = 8'h5A;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_send_data"},  data_in,    fr[i]);
            chk({tag, "_send_rst"},   boe_rst,    1'b0);
            chk({tag, "_send_num"},   data_num,   n);
            chk({tag, "_send_rdy"},   in_ready,   1'b0);
            chk({tag, "_send_done"},  frame_done, 1'b0);
            sum += int'(data_in);
            if (int'(data_in) > mx)
                mx = int'(data_in);
            step();
        end
        for (int w = 0; w < n + 2; w++) begin
            chk({tag, "_wait_data"}, data_in,    8'd0);
            chk({tag, "_wait_rst"},  boe_rst,    1'b0);
            chk({tag, "_wait_num"},  data_num,   n);
            chk({tag, "_wait_rdy"},  in_ready,   1'b0);
            chk({tag, "_wait_err"},  err,        1'b0);
            chk({tag, "_wait_done"}, frame_done, (w == n + 1) ? 1'b1 : 1'b0);
            step();
        end
        in_valid = 1'b0;
        chk({tag, "_idle_rst"},  boe_rst,    1'b1);
        chk({tag, "_idle_rdy"},  in_ready,   1'b1);
        chk({tag, "_idle_num"},  data_num,   3'd0);
        chk({tag, "_idle_done"}, frame_done, 1'b0);
        chk({tag, "_idle_err"},  err,        1'b0);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_max"}, mx,  exp_max);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy"},  in_ready,   1'b0);
        chk({tag, "_brst"}, boe_rst,    1'b1);
        chk({tag, "_num"},  data_num,   3'd0);
        chk({tag, "_data"}, data_in,    8'd0);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_err"},  err,        1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_num   = 3'd0;
        in_data  = 8'd0;

        // Reset state
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();
        chk("reset_rdy_rise", in_ready, 1'b1);
        chk("reset_brst_idle", boe_rst, 1'b1);

        // N=4 {10,200,7,50}: sum 267, max 200
        fr[0] = 8'd10; fr[1] = 8'd200; fr[2] = 8'd7; fr[3] = 8'd50;
        send_frame(3'd4, 4);
        check_play("n4", 4, 267, 200);

        // N=6 all 255: sum 1530, max 255
        for (int i = 0; i < 6; i++)
            fr[i] = 8'd255;
        send_frame(3'd6, 6);
        check_play("n6", 6, 1530, 255);

        // Non-sof beat in IDLE: err pulse, stays IDLE
        beat(1'b0, 3'd0, 8'h33);
        in_valid = 1'b0;
        chk("nosof_err", err, 1'b1);
        chk("nosof_rdy", in_ready, 1'b1);
        chk("nosof_brst", boe_rst, 1'b1);
        step();
        chk("nosof_err_clr", err, 1'b0);
        fr[0] = 8'd1; fr[1] = 8'd2;
        send_frame(3'd2, 2);
        check_play("n2", 2, 3, 2);

        // sof mid-FILL after 2 bytes: err, restart with the new 5-byte frame
        beat(1'b1, 3'd5, 8'hAA);
        beat(1'b0, 3'd0, 8'hBB);
        fr[0] = 8'd11; fr[1] = 8'd22; fr[2] = 8'd33; fr[3] = 8'd44; fr[4] = 8'd55;
        beat(1'b1, 3'd5, fr[0]);
        chk("midsof_err", err, 1'b1);
        chk("midsof_brst", boe_rst, 1'b1);
        beat(1'b0, 3'd0, fr[1]);
        chk("midsof_err_clr", err, 1'b0);
        for (int i = 2; i < 5; i++)
            beat(1'b0, 3'd0, fr[i]);
        check_play("n5", 5, 165, 55);

`ifdef BOE_FEED_LEN_CHECK_EN
        // in_num=7 rejected: err, no launch
        beat(1'b1, 3'd7, 8'd99);
        in_valid = 1'b0;
        chk("len7_err", err, 1'b1);
        chk("len7_rdy", in_ready, 1'b1);
        chk("len7_brst", boe_rst, 1'b1);
        step();
        chk("len7_err_clr", err, 1'b0);
        step();
        chk("len7_no_launch", boe_rst, 1'b1);
        chk("len7_num", data_num, 3'd0);
`else
        // in_num=7 clamped to 6
        fr[0] = 8'd1; fr[1] = 8'd2; fr[2] = 8'd3; fr[3] = 8'd4; fr[4] = 8'd5; fr[5] = 8'd6;
        send_frame(3'd7, 6);
        chk("len7_err", err, 1'b0);
        check_play("len7", 6, 21, 6);
        // in_num=0 clamped to 2
        fr[0] = 8'd100; fr[1] = 8'd101;
        send_frame(3'd0, 2);
        check_play("len0", 2, 201, 101);
`endif

        // rst during WAIT: immediate return to reset values
        fr[0] = 8'd4; fr[1] = 8'd5; fr[2] = 8'd6;
        send_frame(3'd3, 3);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++)
            step();
        chk("midrst_in_wait", boe_rst, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        step();
        rst = 1'b0;
        step();
        chk("midrst_rdy_rise", in_ready, 1'b1);
        fr[0] = 8'd9; fr[1] = 8'd8; fr[2] = 8'd7;
        send_frame(3'd3, 3);
        check_play("n3", 3, 24, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
